// File: rtl/mem_responder_if.sv
// Request/response bus between the multicycle controller and the RAM responder.
// The controller drives the master side; the responder sits on the slave side.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Word-organised RAM responder: one request at a time, fixed access latency,
// byte-masked writes and a registered response held until accepted.
module mem_responder #(
    parameter int ADDR_W  = 11,
    parameter int LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst,
    mem_responder_if.slave bus,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem [2**ADDR_W];

    logic              accept, access, do_write;
    logic              acc_we, acc_err;
    logic [31:0]       acc_addr, acc_wdata;
    logic [3:0]        acc_be;
    logic [ADDR_W-1:0] acc_idx;

    assign bus.req_ready = (state_q == IDLE) && !rst;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign busy          = (state_q != IDLE);

    assign accept = bus.req_valid && bus.req_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        access  = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = LAT_M1;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A single-cycle latency accesses straight from the bus in IDLE
    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_be    = be_q;
        if (state_q == IDLE) begin
            acc_we    = bus.req_we;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
            acc_be    = bus.req_be;
        end
    end

    assign acc_err  = (acc_addr[1:0] != 2'b00) ||
                      ((acc_addr >> (ADDR_W + 2)) != 32'd0);
    assign acc_idx  = acc_addr[ADDR_W+1:2];
    assign do_write = access && !rst && acc_we && !acc_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (access) begin
                rdata_q <= (acc_we || acc_err) ? 32'd0 : mem[acc_idx];
                err_q   <= acc_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
        end
    end

    // Array is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus randomized traffic
// compared against a byte-addressed reference memory.
module tb_mem_responder;

    localparam int ADDR_W = 11;
    localparam int LAT    = 2;

    logic clk = 1'b0;
    logic rst;
    logic busy, busy1;
    int   tests = 0;
    int   fails = 0;

    logic [7:0] mb [int];

    mem_responder_if bus ();
    mem_responder_if bus1 ();

    mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy)
    );

    mem_responder #(.ADDR_W(ADDR_W), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 4 * (2 ** ADDR_W));
    endfunction

    function automatic void model_write(input logic [31:0] a,
                                        input logic [31:0] d,
                                        input logic [3:0] be);
        for (int b = 0; b < 4; b++)
            if (be[b]) mb[int'(a) + b] = d[8*b +: 8];
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = mb[int'(a) + b];
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        int n;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_be    = be;
        n = 0;
        while (!bus.req_ready && n < 40) begin
            step();
            n++;
        end
        check("req_ready_wait", {31'b0, bus.req_ready}, 32'd1);
        step();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.req_be    = 4'($urandom);
    endtask

    task automatic collect(input string tag, output logic [31:0] rd,
                           output logic er);
        int lat;
        lat = 0;
        while (!bus.rsp_valid && lat < 40) begin
            step();
            lat++;
        end
        check({tag, "_valid"}, {31'b0, bus.rsp_valid}, 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(LAT));
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check({tag, "_done"}, {30'b0, bus.rsp_valid, bus.req_ready}, 32'd1);
        check({tag, "_hold"}, bus.rsp_rdata, rd);
    endtask

    task automatic xact(input string tag, input logic we,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] rd,
                        output logic er);
        logic        e;
        logic [31:0] x;
        e = model_err(a);
        x = (we || e) ? 32'd0 : model_read(a);
        issue(we, a, d, be);
        collect(tag, rd, er);
        if (we && !e) model_write(a, d, be);
        check({tag, "_err"}, {31'b0, er}, {31'b0, e});
        check({tag, "_rdata"}, rd, x);
    endtask

    initial begin
        logic [31:0] rd, a, d, snap;
        logic        er;
        logic [31:0] pool [8];
        int          n_acc, n_rsp;
        logic        acc;

        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        bus.rsp_ready = 1'b0;
        bus1.req_valid = 1'b0;
        bus1.req_we    = 1'b0;
        bus1.req_addr  = '0;
        bus1.req_wdata = '0;
        bus1.req_be    = '0;
        bus1.rsp_ready = 1'b0;

        step();
        step();
        check("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
        check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("rst_rdata", bus.rsp_rdata, 32'd0);
        check("rst_err", {31'b0, bus.rsp_err}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        step();
        check("idle_ready", {31'b0, bus.req_ready}, 32'd1);

        xact("w_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er);
        xact("r_full", 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
        check("r_full_const", rd, 32'hDEADBEEF);

        xact("w_mask", 1'b1, 32'h10, 32'h11223344, 4'b0101, rd, er);
        xact("r_mask", 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
        check("r_mask_const", rd, 32'hDE22BE44);

        xact("w_mis", 1'b1, 32'h13, 32'h0, 4'hF, rd, er);
        check("w_mis_const", {31'b0, er}, 32'd1);
        xact("r_after_mis", 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
        check("r_after_mis_const", rd, 32'hDE22BE44);
        xact("r_oor", 1'b0, 32'h2000, 32'h0, 4'h0, rd, er);
        check("r_oor_const", {er, rd[30:0]}, 32'h80000000);

        xact("w_be0", 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, er);
        xact("r_be0", 1'b0, 32'h10, 32'h0, 4'h0, rd, er);

        // Backpressure: response must hold while the next request waits
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        while (!bus.rsp_valid) step();
        snap = bus.rsp_rdata;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h30;
        bus.req_wdata = 32'h55;
        bus.req_be    = 4'hF;
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp_valid", {31'b0, bus.rsp_valid}, 32'd1);
            check("bp_rdata", bus.rsp_rdata, 32'hDE22BE44);
            check("bp_stable", bus.rsp_rdata, snap);
            check("bp_ready", {31'b0, bus.req_ready}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("bp_release", {30'b0, bus.rsp_valid, bus.req_ready}, 32'd1);
        step();
        bus.req_valid = 1'b0;
        check("bp_accepted", {31'b0, busy}, 32'd1);
        collect("bp_w", rd, er);
        model_write(32'h30, 32'h55, 4'hF);
        xact("bp_r", 1'b0, 32'h30, 32'h0, 4'h0, rd, er);

        // Reset while a write is waiting for its access edge
        xact("w_prior", 1'b1, 32'h20, 32'h5, 4'hF, rd, er);
        issue(1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("rst_wait_novalid", {31'b0, bus.rsp_valid}, 32'd0);
            step();
        end
        xact("r_prior", 1'b0, 32'h20, 32'h0, 4'h0, rd, er);
        check("r_prior_const", rd, 32'h5);

        // Randomized traffic over a pre-initialised pool of words
        for (int i = 0; i < 8; i++) begin
            pool[i] = 32'h100 + 32'($urandom_range(0, 255)) * 4;
            xact("rnd_init", 1'b1, pool[i], $urandom, 4'hF, rd, er);
        end
        for (int i = 0; i < 40; i++) begin
            int k;
            k = $urandom_range(0, 99);
            a = pool[$urandom_range(0, 7)];
            if (k < 15) a = a + 32'($urandom_range(1, 3));
            else if (k < 30) a = 32'h2000 + (32'($urandom) & 32'h7FFF_FFFC);
            d = $urandom;
            xact("rnd", 1'($urandom), a, d, 4'($urandom), rd, er);
        end

        // Single-cycle-latency build streams one response every two cycles
        bus1.rsp_ready = 1'b1;
        bus1.req_valid = 1'b1;
        bus1.req_we    = 1'b1;
        bus1.req_addr  = 32'h40;
        bus1.req_wdata = 32'd0;
        bus1.req_be    = 4'hF;
        n_acc = 0;
        n_rsp = 0;
        for (int c = 0; c < 12; c++) begin
            acc = bus1.req_ready && bus1.req_valid;
            step();
            if (acc) begin
                n_acc++;
                bus1.req_wdata = 32'(n_acc);
                if (n_acc == 6) bus1.req_valid = 1'b0;
            end
            if (bus1.rsp_valid) begin
                n_rsp++;
                check("l1_err", {31'b0, bus1.rsp_err}, 32'd0);
            end
        end
        check("l1_accepts", 32'(n_acc), 32'd6);
        check("l1_responses", 32'(n_rsp), 32'd6);
        bus1.req_we    = 1'b0;
        bus1.req_valid = 1'b1;
        step();
        bus1.req_valid = 1'b0;
        check("l1_rvalid", {31'b0, bus1.rsp_valid}, 32'd1);
        check("l1_rdata", bus1.rsp_rdata, 32'd5);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
